// File: rtl/seq_pkg.sv
// Shared definitions for the 1011101 pattern generator / detector link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

   // FSM encoding of the pattern generator
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   // Default pattern, also used by the detector and its bench
   localparam int         SEQ_PAT_W           = 7;
   localparam logic [6:0] SEQ_PATTERN_1011101 = 7'b1011101;

   // Index counter width: covers bit index (PAT_W<=16) and gap count (GAP<=15)
   localparam int         SEQ_IDX_W           = 4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
// Latency: count updates on the clock edge after load/dec.
// Backpressure: none; load has priority over dec.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load wins; decrement only while nonzero so the count never wraps
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial PAT_W-bit pattern transmitter, MSB first, repeated frames with optional idle gaps.
// Latency: first bit on sout the cycle after start is accepted; done one cycle after last bit.
// Backpressure: none downstream; start is accepted only while ready=1. Optional SEQGEN_LOAD_EN adds pattern load.
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int               PAT_W   = SEQ_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN_1011101,
   parameter int               GAP     = 0,
   parameter int               RPT_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [RPT_W-1:0] repeat_cnt,
`ifdef SEQGEN_LOAD_EN
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
`endif
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_last,
   output logic             done
);

   localparam int                   IDX_W    = SEQ_IDX_W;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PAT_W - 1);
   localparam logic [IDX_W-1:0]     GAP_LD   = IDX_W'((GAP > 0) ? GAP - 1 : 0);

   seq_state_t         state;
   logic [PAT_W-1:0]   pat_eff;
   logic [15:0]        pat_ext;
   logic [IDX_W-1:0]   bit_idx;
   logic [IDX_W-1:0]   nxt_idx;
   logic               bit_zero;
   logic               bit_load;
   logic               bit_dec;
   logic [IDX_W-1:0]   bit_val;
   logic [RPT_W-1:0]   frames_left;
   logic               frm_zero;
   logic               frm_load;
   logic               frm_dec;
   logic               unused_frames_left;

`ifdef SEQGEN_LOAD_EN
   logic [PAT_W-1:0]   pat_q;

   // Pattern register: writable only while idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_q <= PATTERN;
      end else if ((state == ST_IDLE) && pat_load) begin
         pat_q <= pat_in;
      end
   end

   // A load coinciding with start must already shape the first bit
   assign pat_eff = ((state == ST_IDLE) && pat_load) ? pat_in : pat_q;
`else
   assign pat_eff = PATTERN;
`endif

   // Zero-extend so a 4-bit index addresses the pattern without width games
   assign pat_ext = 16'(pat_eff);
   assign nxt_idx = bit_idx - IDX_W'(1);

   // Frame count is consumed only through its zero flag; value kept for debug visibility
   assign unused_frames_left = ^frames_left;

   // bit_idx holds the index of the bit currently on sout; in GAP it counts idle cycles
   seq_down_counter #(.W(IDX_W)) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bit_load),
      .load_val (bit_val),
      .dec      (bit_dec),
      .count    (bit_idx),
      .zero     (bit_zero)
   );

   // Remaining extra frames, captured at accept
   seq_down_counter #(.W(RPT_W)) u_frm_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (frm_load),
      .load_val (repeat_cnt),
      .dec      (frm_dec),
      .count    (frames_left),
      .zero     (frm_zero)
   );

   // Counter control derived from the current state
   always_comb begin
      bit_load = 1'b0;
      bit_val  = LAST_IDX;
      bit_dec  = 1'b0;
      frm_load = 1'b0;
      frm_dec  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               bit_load = 1'b1;
               frm_load = 1'b1;
            end
         end
         ST_SEND: begin
            if (bit_zero) begin
               if (!frm_zero) begin
                  frm_dec  = 1'b1;
                  bit_load = 1'b1;
                  if (GAP > 0) begin
                     bit_val = GAP_LD;
                  end
               end
            end else begin
               bit_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (bit_zero) begin
               bit_load = 1'b1;
            end else begin
               bit_dec = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // FSM with registered outputs computed for the state being entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ready      <= 1'b1;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         frame_last <= 1'b0;
         done       <= 1'b0;
      end else begin
         ready      <= 1'b0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         frame_last <= 1'b0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_SEND;
                  sout       <= pat_ext[LAST_IDX];
                  sout_valid <= 1'b1;
               end else begin
                  ready <= 1'b1;
               end
            end
            ST_SEND: begin
               if (!bit_zero) begin
                  sout       <= pat_ext[nxt_idx];
                  sout_valid <= 1'b1;
                  frame_last <= (bit_idx == IDX_W'(1));
               end else if (frm_zero) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else if (GAP > 0) begin
                  state <= ST_GAP;
               end else begin
                  sout       <= pat_ext[LAST_IDX];
                  sout_valid <= 1'b1;
               end
            end
            ST_GAP: begin
               if (bit_zero) begin
                  state      <= ST_SEND;
                  sout       <= pat_ext[LAST_IDX];
                  sout_valid <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: GAP=0 and GAP=3 instances driven with identical stimulus.
// Latency: expected per-cycle outputs queued at accept, popped one per cycle.
// Backpressure: n/a.
module tb_seq_pattern_gen;

   localparam logic [6:0] PAT    = 7'b1011101;
   localparam logic [4:0] IDLE_O = 5'b10000;   // {ready,sout,valid,last,done}

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] repeat_cnt;

   logic rdy0, sout0, vld0, last0, done0;
   logic rdy3, sout3, vld3, last3, done3;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [4:0] exp0[$];
   logic [4:0] exp3[$];

   always #5 clk = ~clk;

   seq_pattern_gen #(.GAP(0)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .repeat_cnt (repeat_cnt),
      .ready      (rdy0),
      .sout       (sout0),
      .sout_valid (vld0),
      .frame_last (last0),
      .done       (done0)
   );

   seq_pattern_gen #(.GAP(3)) dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .repeat_cnt (repeat_cnt),
      .ready      (rdy3),
      .sout       (sout3),
      .sout_valid (vld3),
      .frame_last (last3),
      .done       (done3)
   );

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%b exp=%b ({ready,sout,valid,last,done})", tag, got, exp);
      end
   endtask

   // Expected output stream for one accepted request, per the cycle-level behaviour
   task automatic push_frames(input int which, input int rc, input int gap);
      logic [4:0] e;
      for (int f = 0; f <= rc; f++) begin
         for (int i = 6; i >= 0; i--) begin
            e = {1'b0, PAT[i], 1'b1, (i == 0), 1'b0};
            if (which == 0) exp0.push_back(e); else exp3.push_back(e);
         end
         if (f < rc) begin
            for (int g = 0; g < gap; g++) begin
               if (which == 0) exp0.push_back(5'b00000); else exp3.push_back(5'b00000);
            end
         end
      end
      if (which == 0) exp0.push_back(5'b00001); else exp3.push_back(5'b00001);
   endtask

   // One cycle: check current outputs, then drive inputs for the next edge
   task automatic step(input logic st, input logic [3:0] rc, input logic rn);
      logic       idle0, idle3;
      logic [4:0] e0, e3;
      @(negedge clk);
      idle0 = (exp0.size() == 0);
      idle3 = (exp3.size() == 0);
      e0 = idle0 ? IDLE_O : exp0.pop_front();
      e3 = idle3 ? IDLE_O : exp3.pop_front();
      check($sformatf("gap0_cyc%0d", cyc), {rdy0, sout0, vld0, last0, done0}, e0);
      check($sformatf("gap3_cyc%0d", cyc), {rdy3, sout3, vld3, last3, done3}, e3);
      start      = st;
      repeat_cnt = rc;
      rst_n      = rn;
      if (!rn) begin
         exp0.delete();
         exp3.delete();
      end else begin
         if (idle0 && st) push_frames(0, int'(rc), 0);
         if (idle3 && st) push_frames(1, int'(rc), 3);
      end
      cyc++;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      repeat_cnt = 4'd0;
      repeat (3) @(posedge clk);

      // Reset state, then release
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);

      // Single frame
      step(1'b1, 4'd0, 1'b1);
      repeat (12) step(1'b0, 4'd0, 1'b1);

      // Three frames; repeat_cnt changes after accept must not matter
      step(1'b1, 4'd2, 1'b1);
      repeat (32) step(1'b0, 4'(cyc % 16), 1'b1);

      // Two frames (gap visible on the GAP=3 instance)
      step(1'b1, 4'd1, 1'b1);
      repeat (22) step(1'b0, 4'd0, 1'b1);

      // start held high: no retrigger until ready returns
      repeat (40) step(1'b1, 4'd0, 1'b1);
      repeat (14) step(1'b0, 4'd0, 1'b1);

      // Reset on cycle 4 of a frame: abort, no done pulse
      step(1'b1, 4'd0, 1'b1);
      repeat (3) step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b0);
      repeat (12) step(1'b0, 4'd0, 1'b1);

      // Maximum repeat count must not wrap
      step(1'b1, 4'd15, 1'b1);
      repeat (170) step(1'b0, 4'd0, 1'b1);

      // A few random requests
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 4'($urandom_range(0, 3)), 1'b1);
         repeat (45) step(1'b0, 4'd0, 1'b1);
      end

      if (exp0.size() != 0 || exp3.size() != 0) begin
         n_errors++;
         $display("FAIL drain pending0=%0d pending3=%0d required 0", exp0.size(), exp3.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter. It is the sending end of the 1011101 sequence-detector link.
- On request it shifts a fixed PAT_W-bit pattern out on one serial line, MSB first, one bit per clock.
- The pattern frame can be repeated a set number of times, with optional idle gap cycles between frames.
- It drives the detector's `in` input in system-level tests and on-chip self-test.

Parameters:
- PAT_W, 7, pattern length in bits (2..16).
- PATTERN, 7'b1011101, pattern transmitted MSB first.
- GAP, 0, idle cycles inserted between repeated frames (0..15). Zero means frames are sent back-to-back.
- RPT_W, 4, width of the repeat-count input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low. Sampled on the rising edge of clk.
- start  in  1  request to begin transmission. Accepted only when ready=1.
- repeat_cnt  in  RPT_W  number of extra frames. Total frames = repeat_cnt+1. Captured at accept.
- ready  out  1  high in IDLE only.
- sout  out  1  serial data bit. Driven 0 when sout_valid=0.
- sout_valid  out  1  high on every cycle that carries a pattern bit.
- frame_last  out  1  high together with the final bit of each frame.
- done  out  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; ready=1.
  - sout=0, sout_valid=0, frame_last=0, done=0.
  - Bit index and frame counters cleared.
  - Reset mid-transmission aborts at once. No done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 is accepted; repeat_cnt is latched into frames_left; bit_idx=PAT_W-1; next state SEND.
  - Latency: the first bit appears on sout on the cycle after the accept edge.
  - start while not in IDLE is ignored. It is not queued.
- SEND:
  - Each cycle: sout=PATTERN[bit_idx], sout_valid=1, then bit_idx decrements.
  - frame_last=1 when bit_idx==0.
  - At bit_idx==0:
    - frames_left==0 -> DONE.
    - Else frames_left decrements, bit_idx reloads to PAT_W-1, and the next state is GAP if GAP>0, else SEND.
    - With GAP=0 the frames are contiguous with no bubble.
- GAP:
  - Lasts exactly GAP cycles with sout_valid=0 and sout=0, then goes to SEND.
- DONE:
  - One cycle with done=1, sout_valid=0, then IDLE.
  - ready reasserts on the cycle after the done pulse.
  - start asserted during DONE is ignored.
- Cycle counts:
  - One frame with GAP=0: bits on cycles 1..PAT_W after accept; done on cycle PAT_W+1; ready on cycle PAT_W+2.
  - Total valid bits = (repeat_cnt+1)*PAT_W.
- repeat_cnt at maximum (2^RPT_W-1) must not wrap. The frame counter is RPT_W bits and only decrements while nonzero.

Optional Feature:
- Macro: SEQGEN_LOAD_EN.
- Defined:
  - Adds ports pat_load (in, 1) and pat_in (in, PAT_W).
  - pat_load=1 in IDLE writes pat_in into a pattern register that replaces PATTERN for all later frames.
  - The pattern register resets to PATTERN.
  - If pat_load and start are asserted together in IDLE, the load takes effect first, so the new pattern is sent.
  - pat_load outside IDLE is ignored.
- Undefined:
  - These ports are absent.
  - The pattern is the constant PATTERN.

Decomposition:
- Package seq_pkg holds:
  - the state encoding typedef (IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3);
  - the default constant SEQ_PATTERN_1011101 = 7'b1011101 and SEQ_PAT_W = 7, shared with the detector and its bench.
- One sub-module is natural: seq_down_counter, a loadable down-counter with a zero flag. Instantiate it twice, for bit_idx and for the gap/frame count.

Test Plan:
- Reset, then start=1 with repeat_cnt=0 and defaults -> sout sequence 1,0,1,1,1,0,1 on cycles 1..7; frame_last on cycle 7; done on cycle 8; ready on cycle 9.
- repeat_cnt=2, GAP=0 -> 21 contiguous valid bits (three back-to-back 1011101 frames); frame_last on cycles 7, 14, 21; done on cycle 22.
- GAP=3, repeat_cnt=1 -> valid on cycles 1..7, invalid on 8..10, valid on 11..17; done on cycle 18.
- start held high throughout a frame -> no retrigger mid-frame; a new frame starts only after ready returns.
- rst_n=0 on cycle 4 of a frame -> all outputs 0 next cycle, ready=1, no done pulse.
- With SEQGEN_LOAD_EN: pat_load=1, pat_in=7'b1100110 together with start -> sout 1,1,0,0,1,1,0. Also loop sout into the 1011101 detector: Q asserts exactly once per default frame.
